// File: rtl/riscv_v_skid_stage.sv
// Two-entry skid buffer: registered valid/ready break with in_ready
// driven from state only, plus a saturating stall counter.
module riscv_v_skid_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic [CNT_WIDTH-1:0]  stall_q, stall_d;
  logic                  in_fire;
  logic                  out_fire;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign stall_cnt = stall_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Occupancy mirrors the number of valid registers.
  always_comb begin
    occupancy = 2'd0;
    unique case (state_q)
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Next state and data-register loads; flush wins over any fire.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // Stall counter saturates and ignores flush.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_WIDTH{1'b1}})) begin
      stall_d = stall_q + CNT_WIDTH'(1);
    end
  end

  // State and data registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_riscv_v_skid_stage.sv
// Bench for riscv_v_skid_stage: queue model, directed cases,
// random traffic; second instance exercises 4-bit stall saturation.
module tb_riscv_v_skid_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;
  logic        in_ready4, out_valid4;
  logic [31:0] out_data4;
  logic [1:0]  occupancy4;
  logic [3:0]  stall_cnt4;

  int total = 0;
  int bad = 0;
  int q[$];
  int cnt16 = 0;
  int cnt4 = 0;
  int s;

  riscv_v_skid_stage #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  riscv_v_skid_stage #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .occupancy(occupancy4), .stall_cnt(stall_cnt4)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("in_ready", 32'(in_ready), 32'(n < 2));
    check("out_valid", 32'(out_valid), 32'(n > 0));
    check("occupancy", 32'(occupancy), 32'(n));
    if (n > 0) check("out_data", out_data, 32'(q[0]));
    check("stall_cnt", 32'(stall_cnt), 32'(cnt16));
    check("occupancy4", 32'(occupancy4), 32'(n));
    if (n > 0) check("out_data4", out_data4, 32'(q[0]));
    check("stall_cnt4", 32'(stall_cnt4), 32'(cnt4));
  endtask

  // Called at a negedge: drive, take the edge, advance model, check.
  task automatic cyc(bit iv, int d, bit ordy, bit fl);
    bit ofire, ifire, stall;
    in_valid  = iv;
    in_data   = 32'(d);
    out_ready = ordy;
    flush     = fl;
    ofire = (q.size() > 0) && ordy;
    ifire = iv && (q.size() < 2);
    stall = (q.size() > 0) && !ordy;
    @(posedge clk);
    if (stall) begin
      if (cnt16 < 65535) cnt16++;
      if (cnt4 < 15) cnt4++;
    end
    if (fl) begin
      q.delete();
    end else begin
      if (ofire) void'(q.pop_front());
      if (ifire) q.push_back(d);
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_data = '0;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_all();

    // single beat, one-cycle latency
    cyc(1, 'hA5, 1, 0);
    check("t030_data", out_data, 32'hA5);
    check("t030_occ", 32'(occupancy), 32'd1);
    cyc(0, 0, 1, 0);
    check("t030_drain", 32'(out_valid), 32'd0);

    // fill, stall, drain in order
    cyc(1, 'h11, 0, 0);
    cyc(1, 'h22, 0, 0);
    check("t031_occ", 32'(occupancy), 32'd2);
    check("t031_ready", 32'(in_ready), 32'd0);
    s = cnt16;
    repeat (5) cyc(0, 0, 0, 0);
    check("t031_stall", 32'(stall_cnt), 32'(s + 5));
    check("t031_hold", out_data, 32'h11);
    cyc(0, 0, 1, 0);
    check("t031_second", out_data, 32'h22);
    cyc(0, 0, 1, 0);
    check("t031_empty", 32'(out_valid), 32'd0);

    // full-rate stream
    s = cnt16;
    for (int i = 0; i < 100; i++) begin
      cyc(1, i, 1, 0);
      check("t032_beat", out_data, 32'(i));
    end
    cyc(0, 0, 1, 0);
    check("t032_stall", 32'(stall_cnt), 32'(s));

    // flush while full with an offered beat
    cyc(1, 'h33, 0, 0);
    cyc(1, 'h44, 0, 0);
    cyc(1, 'h55, 0, 1);
    check("t033_occ", 32'(occupancy), 32'd0);
    check("t033_valid", 32'(out_valid), 32'd0);
    check("t033_ready", 32'(in_ready), 32'd1);
    cyc(0, 0, 1, 0);
    check("t033_gone", 32'(out_valid), 32'd0);

    // asynchronous reset pulse while full
    cyc(1, 'h66, 0, 0);
    cyc(1, 'h77, 0, 0);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("t034_valid", 32'(out_valid), 32'd0);
    check("t034_occ", 32'(occupancy), 32'd0);
    check("t034_stall", 32'(stall_cnt), 32'd0);
    #1 rst = 1'b0;
    q.delete(); cnt16 = 0; cnt4 = 0;
    @(negedge clk);
    check_all();
    cyc(1, 'h88, 1, 0);
    check("t034_after", out_data, 32'h88);

    // 4-bit counter saturation
    cyc(1, 'h99, 0, 0);
    repeat (20) cyc(0, 0, 0, 0);
    check("t035_sat", 32'(stall_cnt4), 32'hF);
    cyc(0, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      cyc(bit'($urandom_range(0, 3) != 0), int'($urandom),
          bit'($urandom_range(0, 2) != 0),
          bit'($urandom_range(0, 31) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_v_skid_stage.md
RISCV_V_SKID_STAGE -- requirements
Module: riscv_v_skid_stage

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: payload width in bits (>= 1).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16: stall-counter width in bits (>= 1).
REQ-003 clk  input  1  Single clock; all state updates on posedge clk.
REQ-004 rst  input  1  Asynchronous, active-high reset.
REQ-005 flush  input  1  Synchronous flush; discards all held entries.
REQ-006 in_valid  input  1  Upstream presents in_data.
REQ-007 in_ready  output  1  Block can accept a beat this cycle.
REQ-008 in_data  input  DATA_WIDTH  Upstream payload.
REQ-009 out_valid  output  1  out_data holds a valid beat.
REQ-010 out_ready  input  1  Downstream accepts the beat this cycle.
REQ-011 out_data  output  DATA_WIDTH  Payload to downstream.
REQ-012 occupancy  output  2  Entries held: 0, 1 or 2.
REQ-013 stall_cnt  output  CNT_WIDTH  Count of cycles with out_valid=1 and out_ready=0.

Function
REQ-014 The block SHALL hold a main register (drives out_data) and a skid register, with state EMPTY (0 entries), BUSY (main valid), FULL (main + skid valid).
REQ-015 in_ready SHALL be 1 in EMPTY and BUSY and 0 in FULL; it depends only on state, never combinationally on out_ready.
REQ-016 out_valid SHALL be 1 in BUSY and FULL; occupancy SHALL equal 0/1/2 for EMPTY/BUSY/FULL.
REQ-017 An input fire is in_valid & in_ready; an output fire is out_valid & out_ready.
REQ-018 EMPTY: input fire -> main <= in_data, BUSY; else stay EMPTY.
REQ-019 BUSY: input+output fire -> main <= in_data, stay BUSY; input fire only -> skid <= in_data, FULL; output fire only -> EMPTY; neither -> stay BUSY.
REQ-020 FULL: output fire -> main <= skid, BUSY; else stay FULL, main and skid unchanged.
REQ-021 Latency in_data to out_data SHALL be 1 cycle when the block is EMPTY; sustained throughput SHALL be 1 beat/cycle with out_ready held 1.
REQ-022 Beats SHALL leave in acceptance order; no beat SHALL be dropped or duplicated except by flush or reset.
REQ-023 flush=1 SHALL force state EMPTY on the next edge, overriding any same-cycle input or output fire; a beat offered during the flush cycle is discarded.
REQ-024 out_data SHALL not change while out_valid=1 and out_ready=0 (no flush).
REQ-025 stall_cnt SHALL increment by 1 on each cycle with out_valid=1 and out_ready=0, saturate at all-ones, and be unaffected by flush.
REQ-026 Data registers SHALL load only on the transitions listed; in EMPTY out_data holds its last value (don't-care to consumers).

Reset
REQ-027 While rst=1, state SHALL be EMPTY, in_ready=1, out_valid=0, occupancy=0, stall_cnt=0, main and skid registers=0, independent of clk.
REQ-028 Reset asserted mid-operation SHALL drop all held beats immediately; the first input fire after rst deasserts behaves as from EMPTY.
REQ-029 rst SHALL take priority over flush and all handshakes.

Verification
REQ-030 Reset, then in_valid=1, in_data=0xA5, out_ready=1 for 1 cycle -> next cycle out_valid=1, out_data=0xA5, occupancy=1; following cycle out_valid=0.
REQ-031 out_ready=0, push 0x11 then 0x22 -> occupancy=2, in_ready=0, out_data=0x11; hold 5 cycles -> stall_cnt increases by 5, out_data stays 0x11; out_ready=1 -> 0x11 then 0x22 out in order.
REQ-032 Stream 0..99 with out_ready=1 every cycle -> 100 beats out in order, one per cycle, in_ready constantly 1, stall_cnt=0.
REQ-033 FULL with 0x33/0x44, flush=1 with in_valid=1, in_data=0x55 -> next cycle occupancy=0, out_valid=0, in_ready=1; 0x33, 0x44, 0x55 never appear.
REQ-034 rst pulsed asynchronously between clock edges while FULL -> out_valid=0, occupancy=0, stall_cnt=0 before the next edge.
REQ-035 CNT_WIDTH=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 0xF and holds.
